// File: rtl/display_pkg.sv
// Shared definitions for the date display sequencer.
//   - DATE_TABLE : fixed six-digit BCD dates (MMDDYY), hex5 digit in [23:20]
//   - state_t    : sequencer states
//   - DEF_*      : default timing constants for a 50 MHz clk
//   - date_entry : table lookup; entries beyond the table read as all zeros
package display_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_DWELL_CYCLES    = 100_000_000;
    localparam int DEF_BLANK_CYCLES    = 12_500_000;

    localparam int TABLE_ENTRIES = 4;

    localparam logic [23:0] DATE_TABLE [TABLE_ENTRIES] = '{
        24'h08_23_01,
        24'h08_24_01,
        24'h01_01_00,
        24'h12_31_99
    };

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    function automatic logic [23:0] date_entry(input logic [3:0] idx);
        logic [23:0] entry;
        entry = '0;
        if (idx < 4'(TABLE_ENTRIES)) begin
            entry = DATE_TABLE[idx[1:0]];
        end
        return entry;
    endfunction

endpackage

// File: rtl/key_conditioner.sv
// Conditions one raw active-low push-button.
//   clk     in  : system clock
//   reset   in  : synchronous, active-high
//   key_raw in  : asynchronous raw button level (0 = pressed)
//   press   out : registered single-cycle pulse on an accepted press
// Two-flop synchronizer, then a debounce counter that must see the new level
// for DEBOUNCE_CYCLES consecutive cycles before the debounced level follows.
module key_conditioner
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       valid_q, valid_d;
    logic             armed_q, armed_d;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        valid_d = {valid_q[0], 1'b1};
        // The synchronizer holds a reset value, not a real sample, for two
        // cycles after reset. Arming waits for a genuinely observed release so
        // a button held through reset cannot produce a press.
        armed_d = armed_q | (valid_q[1] & sync2_q);
        deb_d   = deb_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d   = sync2_q;
                press_d = ~sync2_q & armed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            valid_q <= '0;
            armed_q <= 1'b0;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            valid_q <= valid_d;
            armed_q <= armed_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/date_display_sequencer.sv
// Steps or auto-scrolls through the date table with a blanking gap between
// entries.
//   clk        in  : system clock
//   reset      in  : synchronous, active-high
//   key[1:0]   in  : raw buttons, active-low; [0] = next, [1] = previous
//   switch     in  : raw slide switches; [0] = auto-scroll enable
//   digits     out : BCD digits, [23:20] -> hex5 ... [3:0] -> hex0
//   blank      out : force all segments off
//   date_index out : current table entry
//   busy       out : high while blanking
// All outputs are registered.
module date_display_sequencer
    import display_pkg::*;
#(
    parameter int NUM_DATES       = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int DWELL_CYCLES    = DEF_DWELL_CYCLES,
    parameter int BLANK_CYCLES    = DEF_BLANK_CYCLES,
    localparam int IDX_W          = $clog2(NUM_DATES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       key,
    input  logic [9:0]       switch,
    output logic [23:0]      digits,
    output logic             blank,
    output logic [IDX_W-1:0] date_index,
    output logic             busy
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);

    logic press_next, press_prev;
    logic unused_switch;

    assign unused_switch = ^switch[9:1];

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key[0]),
        .press   (press_next)
    );

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key[1]),
        .press   (press_prev)
    );

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [BLANK_W-1:0] bcnt_q, bcnt_d;
    logic               auto_s1_q, auto_s1_d;
    logic               auto_s2_q, auto_s2_d;
    logic [23:0]        digits_q, digits_d;
    logic               blank_q, blank_d;
    logic               busy_q, busy_d;
    logic               step_fwd, step_back;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dwell_d   = '0;
        bcnt_d    = '0;
        auto_s1_d = switch[0];
        auto_s2_d = auto_s1_q;
        step_fwd  = 1'b0;
        step_back = 1'b0;

        case (state_q)
            SHOW: begin
                if (auto_s2_q) begin
                    dwell_d = dwell_q + 1'b1;
                end
                // A lone press beats a coincident auto expiry; both keys at
                // once cancel each other.
                if (press_next && !press_prev) begin
                    step_fwd = 1'b1;
                end else if (press_prev && !press_next) begin
                    step_back = 1'b1;
                end else if (auto_s2_q && dwell_q == DWELL_W'(DWELL_CYCLES - 1)) begin
                    step_fwd = 1'b1;
                end
                if (step_fwd || step_back) begin
                    // Index width equals log2(NUM_DATES), so wrap is free.
                    idx_d   = step_fwd ? idx_q + 1'b1 : idx_q - 1'b1;
                    dwell_d = '0;
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (bcnt_q == BLANK_W'(BLANK_CYCLES - 1)) begin
                    state_d = SHOW;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = SHOW;
        endcase

        digits_d = date_entry(4'(idx_d));
        blank_d  = (state_d == BLANK);
        busy_d   = (state_d == BLANK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SHOW;
            idx_q     <= '0;
            dwell_q   <= '0;
            bcnt_q    <= '0;
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
            digits_q  <= DATE_TABLE[0];
            blank_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dwell_q   <= dwell_d;
            bcnt_q    <= bcnt_d;
            auto_s1_q <= auto_s1_d;
            auto_s2_q <= auto_s2_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            busy_q    <= busy_d;
        end
    end

    assign digits     = digits_q;
    assign blank      = blank_q;
    assign busy       = busy_q;
    assign date_index = idx_q;

endmodule
